mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of BUSY cycles to wait for mem_ack (legal range 1..255).
REQ-002 SHALL have one clock and an asynchronous active-low reset; the ports are listed below.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemReadM  in  1  load request from the EX/MEM register
- MemWriteM  in  1  store request from the EX/MEM register
- MemtoRegM  in  1  writeback select from the EX/MEM register
- RegWriteM  in  1  register-write enable from the EX/MEM register
- ALUResultAddrM  in  32  byte address, or the ALU result for non-memory instructions
- DataWriteInM  in  32  store data
- RegisterDstM  in  5  destination register
- mem_req, mem_we  out  1 each  bus request and bus write-enable
- mem_addr, mem_wdata  out  32 each  bus address and bus write data
- mem_ack  in  1  one-cycle bus completion
- mem_rdata  in  32  bus read data, valid while mem_ack=1
- stall_M  out  1  hold upstream pipeline registers
- RegWriteW, MemtoRegW  out  1 each  MEM/WB control
- ReadDataW, ALUResultW  out  32 each  MEM/WB data
- RegisterDstW  out  5  MEM/WB destination register
- bus_err, misalign_err  out  1 each  one-cycle error pulses

Function
REQ-003 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-004 SHALL treat "access" as MemReadM|MemWriteM; when both are high, the access SHALL be a write.
REQ-005 IDLE with access: stall_M=1 combinationally; at the next edge SHALL latch the address, wdata and we onto the bus outputs, set mem_req=1 and go to BUSY.
REQ-006 BUSY: stall_M=1 and mem_req=1, with mem_addr, mem_wdata and mem_we held stable; mem_ack=1 at an edge -> capture mem_rdata, mem_req=0, go to DONE.
REQ-007 BUSY cycle counter: when TIMEOUT BUSY cycles pass without mem_ack -> go to DONE, bus_err=1 for the DONE cycle, captured rdata=0.
REQ-008 DONE: stall_M=0; at the next edge the MEM/WB outputs load and the FSM returns to IDLE.
REQ-009 SHALL ignore mem_ack in IDLE and DONE.
REQ-010 IDLE without access: stall_M=0; at the edge the MEM/WB outputs load pass-through values, with ReadDataW=0.
REQ-011 While stall_M=1, at each edge the MEM/WB outputs SHALL load a bubble (RegWriteW=0, MemtoRegW=0), so there is never a duplicate writeback.
REQ-012 On the DONE edge: RegWriteW=RegWriteM, except that it SHALL be forced to 0 when bus_err or misalign_err is set; MemtoRegW, ALUResultW and RegisterDstW SHALL be copied from the M-side inputs; ReadDataW=captured rdata.
REQ-013 Minimum load/store latency SHALL be 3 cycles: IDLE stall, BUSY with ack, DONE.
REQ-014 mem_we SHALL be 0 whenever mem_req=0.

Reset
REQ-015 rst_n=0 SHALL immediately force the FSM to IDLE, and SHALL immediately force all outputs and the counter to 0, including mid-BUSY; any in-flight access SHALL be abandoned.
REQ-016 The first access after reset deassertion SHALL follow REQ-005 with no extra cycle.

Configuration
REQ-017 Macro MEM_ALIGN_CHECK_EN. Defined: an access with ALUResultAddrM[1:0]!=0 SHALL issue no bus request and go from IDLE directly to DONE, with misalign_err=1 for the DONE cycle.
REQ-018 Undefined: misalign_err SHALL be tied to 0 and the address SHALL pass unchecked.

Structure
REQ-019 The FSM state enum, the TIMEOUT default and the counter width constant SHALL live in shared package mem_pkg.
REQ-020 The FSM and timeout counter SHALL be sub-module mem_req_fsm; the MEM/WB output registers SHALL stay in the top level.

Verification
REQ-021 Load: addr 0x10 with mem_ack at the 1st BUSY cycle and rdata 0xDEADBEEF -> stall_M high for 2 cycles; ReadDataW=0xDEADBEEF, RegWriteW=1, RegisterDstW matches after the DONE edge.
REQ-022 Store: addr 0x20, data 0x12345678, ack after 3 BUSY cycles -> mem_we=1 and mem_wdata stable for 3 cycles; stall_M lasts 4 cycles.
REQ-023 Timeout with TIMEOUT=4 and no ack -> bus_err pulses once after 4 BUSY cycles; RegWriteW=0, ReadDataW=0.
REQ-024 Reset mid-BUSY: rst_n=0 -> mem_req=0 immediately and the FSM is in IDLE; after release, a new load completes normally.
REQ-025 Non-memory instruction (RegWriteM=1, ALUResultAddrM=0x55) -> no stall; ALUResultW=0x55 at the next edge.
REQ-026 With MEM_ALIGN_CHECK_EN, a load at 0x13 -> mem_req never rises; misalign_err pulses once; RegWriteW=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit: FSM states,
// default bus timeout and the width of the BUSY cycle counter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;   // wide enough for TIMEOUT up to 255

endpackage

// File: rtl/mem_req_fsm.sv
// Bus request sequencer: IDLE -> BUSY -> DONE with a BUSY-cycle timeout.
// Owns the bus-side registers, the captured read data and the error pulses.
module mem_req_fsm import mem_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        access,
  input  logic        isWrite,
  input  logic        misaligned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output memState_t   state,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic        busErr,
  output logic        misalignErr,
  output logic [31:0] rdataCap
);

  memState_t        nextState;
  logic [CNT_W-1:0] cnt;
  logic             timeoutHit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState  = state;
    stall      = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: if (access) begin
        stall     = 1'b1;
        nextState = misaligned ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        // an ack on the final allowed cycle still wins over the timeout
        if (mem_ack) nextState = DONE;
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          nextState  = DONE;
          timeoutHit = 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      busErr      <= 1'b0;
      misalignErr <= 1'b0;
      rdataCap    <= '0;
    end else begin
      busErr      <= 1'b0;
      misalignErr <= 1'b0;
      case (state)
        IDLE: if (access) begin
          cnt      <= '0;
          rdataCap <= '0;
          if (misaligned) misalignErr <= 1'b1;
          else begin
            memReq   <= 1'b1;
            memWe    <= isWrite;
            memAddr  <= addr;
            memWdata <= wdata;
          end
        end
        BUSY: if (nextState == DONE) begin
          memReq   <= 1'b0;
          memWe    <= 1'b0;
          busErr   <= timeoutHit;
          rdataCap <= mem_ack ? mem_rdata : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage bus access unit with MEM/WB pipeline registers.
// Optional MEM_ALIGN_CHECK_EN: word-misaligned accesses skip the bus and flag misalign_err.
module mem_access_unit import mem_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUResultAddrM,
  input  logic [31:0] DataWriteInM,
  input  logic [4:0]  RegisterDstM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_M,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RegisterDstW,
  output logic        bus_err,
  output logic        misalign_err
);

  logic        access;
  logic        misaligned;
  logic        fsmStall;
  logic [31:0] rdataCap;
  memState_t   state;

  assign access = MemReadM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |ALUResultAddrM[1:0];
`else
  assign misaligned = 1'b0;
`endif

  mem_req_fsm #(.TIMEOUT(TIMEOUT)) uFsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .access     (access),
    .isWrite    (MemWriteM),
    .misaligned (misaligned),
    .addr       (ALUResultAddrM),
    .wdata      (DataWriteInM),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .state      (state),
    .stall      (fsmStall),
    .memReq     (mem_req),
    .memWe      (mem_we),
    .memAddr    (mem_addr),
    .memWdata   (mem_wdata),
    .busErr     (bus_err),
    .misalignErr(misalign_err),
    .rdataCap   (rdataCap)
  );

  // stall is combinational from the inputs, so gate it to read 0 while in reset
  assign stall_M = rst_n & fsmStall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      ReadDataW    <= '0;
      ALUResultW   <= '0;
      RegisterDstW <= '0;
    end else if (stall_M) begin
      // bubble: the held instruction must not write back more than once
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else if (state == DONE) begin
      RegWriteW    <= RegWriteM & ~(bus_err | misalign_err);
      MemtoRegW    <= MemtoRegM;
      ReadDataW    <= rdataCap;
      ALUResultW   <= ALUResultAddrM;
      RegisterDstW <= RegisterDstM;
    end else begin
      RegWriteW    <= RegWriteM;
      MemtoRegW    <= MemtoRegM;
      ReadDataW    <= '0;
      ALUResultW   <= ALUResultAddrM;
      RegisterDstW <= RegisterDstM;
    end
  end

endmodule
